alu_datapath: RTL and testbench
===============================

Name: alu_datapath

Overview:
- Parametrised successor to the single-adder 8-bit datapath.
- Contains NREGS general registers, a Y operand latch, a 4-op ALU and a Z result register, all joined by one shared internal bus.
- An internal T-state sequencer runs one three-operand instruction per start pulse: R[rc] <= R[ra] op R[rb], or imm op R[rb].
- Bus sequencing is handled inside the block, so the control unit only issues start/op/select and waits for done.

Parameters:
WIDTH, 8, data/bus/register width in bits (>=2)
NREGS, 4, number of general registers (2..16); selector width SELW = max(1, clog2(NREGS)) is a derived localparam

Ports:
clock  in  1  system clock, all state on rising edge
clear  in  1  synchronous active-high reset
start  in  1  request to execute one operation; sampled only in IDLE
op  in  2  ALU operation (see Behaviour)
ra_sel  in  SELW  first source register
rb_sel  in  SELW  second source register
rc_sel  in  SELW  destination register
imm_en  in  1  1: first operand is imm instead of R[ra_sel]
imm  in  WIDTH  immediate operand
busy  out  1  high while an operation is in flight (state != IDLE)
done  out  1  one-cycle pulse: operation retired
result  out  WIDTH  last value written back (registered)
carry  out  1  carry/borrow flag of last ADD/SUB, registered
bus_out  out  WIDTH  current internal bus value (debug/observe)
rd_sel  in  SELW  asynchronous debug read select
rd_data  out  WIDTH  R[rd_sel], combinational

Behaviour:
- Reset (clear=1 at an edge): all R[i], Y, Z, result and carry go to 0; state goes to IDLE; busy=0, done=0. Reset overrides start. Reset mid-operation abandons the operation with no write-back and no done.
- States: IDLE -> T1 -> T2 -> T3 -> DONE -> IDLE.
- Acceptance:
  - At an edge with state=IDLE and start=1, op, ra_sel, rb_sel, rc_sel, imm_en and imm are captured into internal holding registers; state goes to T1.
  - Later changes on these inputs have no effect on the in-flight operation.
  - start in any other state is ignored (no queueing).
- T1: bus = imm_en ? imm : R[ra]; Y <= bus at the closing edge.
- T2: bus = R[rb]; Z <= ALU(Y, bus) and carry <= ALU carry at the closing edge.
- T3: bus = Z; R[rc] <= bus and result <= Z at the closing edge.
- DONE: done=1 for exactly this cycle; bus = 0.
- IDLE: bus = 0.
- Latency and throughput:
  - start sampled at edge k gives the write at edge k+3 and done high between edges k+3 and k+4.
  - With start held high, the next acceptance is at edge k+5, so maximum rate is one operation per 5 cycles.
- ALU (all results modulo 2^WIDTH, unsigned):
  - 00 ADD: Y+B; carry = carry-out.
  - 01 SUB: Y-B; carry = borrow (1 iff Y<B).
  - 10 AND: carry <= 0.
  - 11 OR: carry <= 0.
- Aliasing: any of ra, rb and rc may be equal. Sources are read in T1/T2, before the T3 write, so R[1] <= R[1]+R[1] doubles the value.
- Selector >= NREGS (non-power-of-2 NREGS): the read returns 0 and the write is dropped; done still pulses.
- rd_data reflects a write from the cycle after the T3 edge.

Decomposition:
- Package alu_datapath_pkg holds:
  - op encodings OP_ADD/OP_SUB/OP_AND/OP_OR;
  - state encodings ST_IDLE/ST_T1/ST_T2/ST_T3/ST_DONE.
- One sub-module, dp_alu: combinational, parametrised by WIDTH; inputs a, b, op; outputs y, cout.
- Register file, Y/Z latches, bus mux and sequencer stay in alu_datapath.

Test Plan:
- Reset: write via ops, then assert clear during T2 -> next cycle busy=0, all rd_data=0x00, result=0, carry=0, no done pulse; hold clear with start=1 -> state stays IDLE.
- Immediate loads and ADD:
  - imm_en=1, imm=0x05, op=OR, rb=R0 (=0), rc=R1 -> R1=0x05 with done at k+3.
  - Load R2=0xFE the same way.
  - ADD ra=1, rb=2, rc=3 -> R3=0x03, carry=1, result=0x03.
- SUB borrow: R1=0x05, R2=0xFE; SUB ra=1, rb=2, rc=0 -> R0=0x07, carry=1. Swapped (ra=2, rb=1) -> 0xF9, carry=0.
- Aliasing and logic: R1=0x05; ADD ra=1, rb=1, rc=1 -> R1=0x0A. AND imm=0x0F with R2=0xFE -> 0x0E, carry=0.
- Handshake:
  - Hold start=1 continuously -> acceptances exactly every 5 cycles.
  - Change op/selects mid-flight -> the in-flight result is unaffected.
  - busy=1 for 4 cycles per operation; done is a single-cycle pulse.
  - bus_out sequence for the first ADD test: 0x05, 0xFE, 0x03, then 0.
- Parametrised NREGS=3, WIDTH=16:
  - ADD 0xFFFF+0x0001 -> 0x0000, carry=1.
  - rc_sel=3 -> no register changes, done pulses.

Source files
------------

// File: rtl/alu_datapath_pkg.sv
// Shared encodings for the bus-sequenced ALU datapath: ALU opcodes, sequencer
// states and the selector-width helper used to size register selectors.
package alu_datapath_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // A single register still needs a one-bit selector.
    function automatic int sel_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational 4-op ALU: ADD/SUB report carry-out/borrow, logic ops clear it.
module dp_alu
    import alu_datapath_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    // Operation select; the extra MSB of the widened sum/difference is carry/borrow.
    always_comb begin
        y    = {WIDTH{1'b0}};
        cout = 1'b0;
        case (op)
            OP_ADD:  {cout, y} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {cout, y} = {1'b0, a} - {1'b0, b};
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: begin
                y    = {WIDTH{1'b0}};
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_datapath.sv
// Register file, Y/Z latches and one shared bus driven by a T-state sequencer
// that executes R[rc] <= (imm | R[ra]) op R[rb] per accepted start.
module alu_datapath
    import alu_datapath_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    localparam int SELW  = sel_w(NREGS)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [SELW-1:0]  ra_sel,
    input  logic [SELW-1:0]  rb_sel,
    input  logic [SELW-1:0]  rc_sel,
    input  logic             imm_en,
    input  logic [WIDTH-1:0] imm,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic [WIDTH-1:0] bus_out,
    input  logic [SELW-1:0]  rd_sel,
    output logic [WIDTH-1:0] rd_data
);

    state_e           state_r, state_s;
    op_e              op_r;
    logic [SELW-1:0]  ra_r, rb_r, rc_r;
    logic             imm_en_r;
    logic [WIDTH-1:0] imm_r;
    logic [WIDTH-1:0] regs_r [NREGS];
    logic [WIDTH-1:0] y_r, z_r, result_r;
    logic             carry_r, busy_r, done_r;
    logic [WIDTH-1:0] ra_val_s, rb_val_s, rd_val_s, bus_s, alu_y_s;
    logic             alu_c_s;

    // Register reads; a selector beyond NREGS matches nothing and reads 0.
    always_comb begin
        ra_val_s = {WIDTH{1'b0}};
        rb_val_s = {WIDTH{1'b0}};
        rd_val_s = {WIDTH{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            if (ra_r == SELW'(i)) ra_val_s = regs_r[i];
            else                  ra_val_s = ra_val_s;
            if (rb_r == SELW'(i)) rb_val_s = regs_r[i];
            else                  rb_val_s = rb_val_s;
            if (rd_sel == SELW'(i)) rd_val_s = regs_r[i];
            else                    rd_val_s = rd_val_s;
        end
    end

    // Next-state decode of the T-state sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_T1;
                else       state_s = ST_IDLE;
            end
            ST_T1:   state_s = ST_T2;
            ST_T2:   state_s = ST_T3;
            ST_T3:   state_s = ST_DONE;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Shared bus source per T-state; parked at zero when idle or retiring.
    always_comb begin
        bus_s = {WIDTH{1'b0}};
        case (state_r)
            ST_T1: begin
                if (imm_en_r) bus_s = imm_r;
                else          bus_s = ra_val_s;
            end
            ST_T2:   bus_s = rb_val_s;
            ST_T3:   bus_s = z_r;
            default: bus_s = {WIDTH{1'b0}};
        endcase
    end

    dp_alu #(.WIDTH(WIDTH)) u_alu (
        .a    (y_r),
        .b    (bus_s),
        .op   (op_r),
        .y    (alu_y_s),
        .cout (alu_c_s)
    );

    // Sequencer state plus busy/done decoded from the next state so they are registered.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Instruction holding registers, loaded only on acceptance.
    always_ff @(posedge clock) begin
        if (clear) begin
            op_r     <= OP_ADD;
            ra_r     <= {SELW{1'b0}};
            rb_r     <= {SELW{1'b0}};
            rc_r     <= {SELW{1'b0}};
            imm_en_r <= 1'b0;
            imm_r    <= {WIDTH{1'b0}};
        end else if ((state_r == ST_IDLE) && start) begin
            op_r     <= op_e'(op);
            ra_r     <= ra_sel;
            rb_r     <= rb_sel;
            rc_r     <= rc_sel;
            imm_en_r <= imm_en;
            imm_r    <= imm;
        end
    end

    // Y/Z latches, carry flag and result, each loaded in its own T-state.
    always_ff @(posedge clock) begin
        if (clear) begin
            y_r      <= {WIDTH{1'b0}};
            z_r      <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            result_r <= {WIDTH{1'b0}};
        end else begin
            if (state_r == ST_T1) y_r <= bus_s;
            if (state_r == ST_T2) begin
                z_r     <= alu_y_s;
                carry_r <= alu_c_s;
            end
            if (state_r == ST_T3) result_r <= z_r;
        end
    end

    // Write-back in T3; an out-of-range rc matches no register and is dropped.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NREGS; i++) begin
            if (clear)                                       regs_r[i] <= {WIDTH{1'b0}};
            else if ((state_r == ST_T3) && (rc_r == SELW'(i))) regs_r[i] <= bus_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign result  = result_r;
    assign carry   = carry_r;
    assign bus_out = bus_s;
    assign rd_data = rd_val_s;

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench: an 8-bit/4-register instance and a 16-bit/3-register instance
// checked against hand-computed register, flag, bus and handshake values.
module tb_alu_datapath;

    logic        clock;
    logic        clear_a, clear_b, start_a, start_b;
    logic [1:0]  op;
    logic [1:0]  ra_sel, rb_sel, rc_sel, rd_sel;
    logic        imm_en;
    logic [15:0] imm;

    logic        busy_a, done_a, carry_a;
    logic [7:0]  result_a, bus_a, rd_a;
    logic        busy_b, done_b, carry_b;
    logic [15:0] result_b, bus_b, rd_b;

    int          passed = 0;
    int          total  = 0;
    logic [15:0] bus_t1, bus_t2, bus_t3;
    int          acc_cyc [3];
    int          nacc, ndone;
    logic        prev_busy;

    alu_datapath #(.WIDTH(8), .NREGS(4)) dut_a (
        .clock(clock), .clear(clear_a), .start(start_a), .op(op),
        .ra_sel(ra_sel), .rb_sel(rb_sel), .rc_sel(rc_sel),
        .imm_en(imm_en), .imm(imm[7:0]),
        .busy(busy_a), .done(done_a), .result(result_a), .carry(carry_a),
        .bus_out(bus_a), .rd_sel(rd_sel), .rd_data(rd_a)
    );

    alu_datapath #(.WIDTH(16), .NREGS(3)) dut_b (
        .clock(clock), .clear(clear_b), .start(start_b), .op(op),
        .ra_sel(ra_sel), .rb_sel(rb_sel), .rc_sel(rc_sel),
        .imm_en(imm_en), .imm(imm),
        .busy(busy_b), .done(done_b), .result(result_b), .carry(carry_b),
        .bus_out(bus_b), .rd_sel(rd_sel), .rd_data(rd_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] o_busy(input bit b);
        return b ? {15'd0, busy_b} : {15'd0, busy_a};
    endfunction
    function automatic logic [15:0] o_done(input bit b);
        return b ? {15'd0, done_b} : {15'd0, done_a};
    endfunction
    function automatic logic [15:0] o_bus(input bit b);
        return b ? bus_b : {8'd0, bus_a};
    endfunction

    task automatic rd(input bit b, input logic [1:0] sel, input logic [15:0] exp, input string tag);
        rd_sel = sel;
        #1;
        chk(tag, b ? rd_b : {8'd0, rd_a}, exp);
    endtask

    // One operation: accept, scramble inputs mid-flight, check busy/done/bus timing.
    task automatic run(input bit b, input logic [1:0] o, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [1:0] rc,
                       input logic ie, input logic [15:0] im, input string tag);
        op = o; ra_sel = ra; rb_sel = rb; rc_sel = rc; imm_en = ie; imm = im;
        if (b) start_b = 1'b1;
        else   start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        chk({tag, ".busy_t1"}, o_busy(b), 16'd1);
        chk({tag, ".done_t1"}, o_done(b), 16'd0);
        bus_t1 = o_bus(b);
        op = ~o; ra_sel = ~ra; rb_sel = ~rb; rc_sel = ~rc; imm_en = ~ie; imm = ~im;
        tick();
        bus_t2 = o_bus(b);
        tick();
        bus_t3 = o_bus(b);
        chk({tag, ".done_t3"}, o_done(b), 16'd0);
        tick();
        chk({tag, ".done_pulse"}, o_done(b), 16'd1);
        chk({tag, ".busy_done"}, o_busy(b), 16'd1);
        chk({tag, ".bus_done"}, o_bus(b), 16'd0);
        tick();
        chk({tag, ".done_end"}, o_done(b), 16'd0);
        chk({tag, ".busy_end"}, o_busy(b), 16'd0);
    endtask

    initial begin
        clear_a = 1'b1; clear_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        op = 2'd0; ra_sel = 2'd0; rb_sel = 2'd0; rc_sel = 2'd0; rd_sel = 2'd0;
        imm_en = 1'b0; imm = 16'h0000;
        tick();
        tick();
        clear_a = 1'b0; clear_b = 1'b0;
        tick();
        chk("rst.busy", {15'd0, busy_a}, 16'd0);
        chk("rst.done", {15'd0, done_a}, 16'd0);
        chk("rst.result", {8'd0, result_a}, 16'h0000);
        chk("rst.carry", {15'd0, carry_a}, 16'd0);
        chk("rst.bus", {8'd0, bus_a}, 16'h0000);
        rd(1'b0, 2'd1, 16'h0000, "rst.r1");

        // Immediate loads, then ADD with carry-out and bus trace.
        run(1'b0, 2'd3, 2'd0, 2'd0, 2'd1, 1'b1, 16'h0005, "ld_r1");
        rd(1'b0, 2'd1, 16'h0005, "ld_r1.r1");
        run(1'b0, 2'd3, 2'd0, 2'd0, 2'd2, 1'b1, 16'h00FE, "ld_r2");
        rd(1'b0, 2'd2, 16'h00FE, "ld_r2.r2");
        run(1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 16'h0000, "add");
        chk("add.bus_t1", bus_t1, 16'h0005);
        chk("add.bus_t2", bus_t2, 16'h00FE);
        chk("add.bus_t3", bus_t3, 16'h0003);
        rd(1'b0, 2'd3, 16'h0003, "add.r3");
        chk("add.carry", {15'd0, carry_a}, 16'd1);
        chk("add.result", {8'd0, result_a}, 16'h0003);

        // Subtraction with and without borrow, logic op clears carry.
        run(1'b0, 2'd1, 2'd1, 2'd2, 2'd0, 1'b0, 16'h0000, "sub");
        rd(1'b0, 2'd0, 16'h0007, "sub.r0");
        chk("sub.carry", {15'd0, carry_a}, 16'd1);
        run(1'b0, 2'd2, 2'd0, 2'd2, 2'd3, 1'b1, 16'h000F, "and");
        rd(1'b0, 2'd3, 16'h000E, "and.r3");
        chk("and.carry", {15'd0, carry_a}, 16'd0);
        chk("and.result", {8'd0, result_a}, 16'h000E);
        run(1'b0, 2'd1, 2'd2, 2'd1, 2'd0, 1'b0, 16'h0000, "subsw");
        rd(1'b0, 2'd0, 16'h00F9, "subsw.r0");
        chk("subsw.carry", {15'd0, carry_a}, 16'd0);
        run(1'b0, 2'd0, 2'd1, 2'd1, 2'd1, 1'b0, 16'h0000, "alias");
        rd(1'b0, 2'd1, 16'h000A, "alias.r1");
        rd(1'b0, 2'd2, 16'h00FE, "alias.r2");

        // Start held high: acceptances every 5 cycles, R0 += 1 three times.
        op = 2'd0; ra_sel = 2'd0; rb_sel = 2'd0; rc_sel = 2'd0; imm_en = 1'b1; imm = 16'h0001;
        start_a = 1'b1;
        nacc = 0; ndone = 0; prev_busy = busy_a;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (busy_a && !prev_busy && nacc < 3) begin
                acc_cyc[nacc] = c;
                nacc++;
            end
            if (done_a) ndone++;
            prev_busy = busy_a;
        end
        start_a = 1'b0;
        chk("hold.nacc", 16'(nacc), 16'd3);
        chk("hold.first", 16'(acc_cyc[0]), 16'd1);
        chk("hold.gap1", 16'(acc_cyc[1] - acc_cyc[0]), 16'd5);
        chk("hold.gap2", 16'(acc_cyc[2] - acc_cyc[1]), 16'd5);
        chk("hold.ndone", 16'(ndone), 16'd3);
        rd(1'b0, 2'd0, 16'h00FC, "hold.r0");

        // Clear during T2 abandons the operation; clear overrides start.
        op = 2'd0; ra_sel = 2'd1; rb_sel = 2'd2; rc_sel = 2'd3; imm_en = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        clear_a = 1'b1;
        start_a = 1'b1;
        tick();
        chk("clr.busy", {15'd0, busy_a}, 16'd0);
        chk("clr.done", {15'd0, done_a}, 16'd0);
        chk("clr.result", {8'd0, result_a}, 16'h0000);
        chk("clr.carry", {15'd0, carry_a}, 16'd0);
        rd(1'b0, 2'd0, 16'h0000, "clr.r0");
        rd(1'b0, 2'd1, 16'h0000, "clr.r1");
        rd(1'b0, 2'd2, 16'h0000, "clr.r2");
        rd(1'b0, 2'd3, 16'h0000, "clr.r3");
        tick();
        chk("clr.hold_busy", {15'd0, busy_a}, 16'd0);
        clear_a = 1'b0;
        start_a = 1'b0;
        tick();
        chk("clr.after_done1", {15'd0, done_a}, 16'd0);
        tick();
        chk("clr.after_done2", {15'd0, done_a}, 16'd0);
        chk("clr.after_busy", {15'd0, busy_a}, 16'd0);
        rd(1'b0, 2'd3, 16'h0000, "clr.no_wb");

        // 16-bit, 3-register instance: wrap-around carry and out-of-range selectors.
        run(1'b1, 2'd3, 2'd0, 2'd0, 2'd0, 1'b1, 16'hFFFF, "b.ld_r0");
        run(1'b1, 2'd3, 2'd0, 2'd1, 2'd1, 1'b1, 16'h0001, "b.ld_r1");
        run(1'b1, 2'd3, 2'd0, 2'd2, 2'd2, 1'b1, 16'h1234, "b.ld_r2");
        rd(1'b1, 2'd2, 16'h1234, "b.ld_r2.r2");
        run(1'b1, 2'd0, 2'd0, 2'd1, 2'd2, 1'b0, 16'h0000, "b.add");
        rd(1'b1, 2'd2, 16'h0000, "b.add.r2");
        chk("b.add.carry", {15'd0, carry_b}, 16'd1);
        chk("b.add.result", result_b, 16'h0000);
        run(1'b1, 2'd3, 2'd0, 2'd1, 2'd3, 1'b1, 16'h5555, "b.rc3");
        rd(1'b1, 2'd0, 16'hFFFF, "b.rc3.r0");
        rd(1'b1, 2'd1, 16'h0001, "b.rc3.r1");
        rd(1'b1, 2'd2, 16'h0000, "b.rc3.r2");
        rd(1'b1, 2'd3, 16'h0000, "b.rc3.rd3");
        chk("b.rc3.result", result_b, 16'h5555);
        run(1'b1, 2'd0, 2'd3, 2'd1, 2'd2, 1'b0, 16'h0000, "b.ra3");
        rd(1'b1, 2'd2, 16'h0001, "b.ra3.r2");
        chk("b.ra3.carry", {15'd0, carry_b}, 16'd0);
        chk("a.idle_during_b", {15'd0, busy_a}, 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
